// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor slice.
//   - ctr_e: 2-bit saturating direction counter encodings
//   - DELAY_SLOT_OFFSET: fall-through distance past the branch delay slot
//   - default table geometry (index and tag widths)
package branch_predictor_pkg;

    localparam int          IDX_W_DEFAULT     = 4;
    localparam int          TAG_W_DEFAULT     = 8;
    localparam logic [31:0] DELAY_SLOT_OFFSET = 32'd8;

    // Counter bit 1 is the predicted direction.
    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

endpackage

// File: rtl/branch_predictor_if.sv
// Signal bundle between the pipeline front end and the branch predictor.
//   IF side : if_pc -> pred_taken, pred_target
//   ID side : id_stall, id_flush, res_valid, res_pc, res_taken, res_target
//             -> mispredict, redirect_pc
//   status  : mispredict_cnt
// Handshake: there is no ready. A resolution is consumed in exactly the
// cycle where res_valid=1 and neither id_stall nor id_flush is set; in any
// other cycle the res_* fields are ignored and nothing is updated.
interface branch_predictor_if;

    logic        [31:0] if_pc;
    logic               pred_taken;
    logic        [31:0] pred_target;
    logic               id_stall;
    logic               id_flush;
    logic               res_valid;
    logic        [31:0] res_pc;
    logic               res_taken;
    logic        [31:0] res_target;
    logic               mispredict;
    logic        [31:0] redirect_pc;
    logic        [31:0] mispredict_cnt;

    modport master (
        output if_pc, id_stall, id_flush, res_valid, res_pc, res_taken, res_target,
        input  pred_taken, pred_target, mispredict, redirect_pc, mispredict_cnt
    );

    modport slave (
        input  if_pc, id_stall, id_flush, res_valid, res_pc, res_taken, res_target,
        output pred_taken, pred_target, mispredict, redirect_pc, mispredict_cnt
    );

endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state function of the 2-bit saturating direction counter.
//   cur   : current counter value
//   taken : resolved branch direction
//   nxt   : counter stepped toward taken/not-taken, clamped at ST/SNT
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  ctr_e cur,
    input  logic taken,
    output ctr_e nxt
);

    always_comb begin
        nxt = cur;
        if (taken) begin
            if (cur != CTR_ST) nxt = ctr_e'(cur + 2'd1);
        end else begin
            if (cur != CTR_SNT) nxt = ctr_e'(cur - 2'd1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch direction/target predictor.
//   clk, rst_n : clock, synchronous active-low reset
//   bp (slave) : IF lookup (if_pc -> pred_taken/pred_target), ID resolution
//                (res_* -> mispredict/redirect_pc), mispredict_cnt status
// The prediction made at IF travels with the instruction in the pid_*
// register and is compared against the ID-stage branch decision.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEFAULT,
    parameter int TAG_W = TAG_W_DEFAULT
) (
    input logic             clk,
    input logic             rst_n,
    branch_predictor_if.slave bp
);

    localparam int N = 1 << IDX_W;

    logic             valid_q  [N];
    logic             valid_d  [N];
    logic [TAG_W-1:0] tag_q    [N];
    logic [TAG_W-1:0] tag_d    [N];
    logic [31:0]      target_q [N];
    logic [31:0]      target_d [N];
    ctr_e             ctr_q    [N];
    ctr_e             ctr_d    [N];

    logic        pid_taken_q, pid_taken_d;
    logic [31:0] pid_target_q, pid_target_d;
    logic [31:0] mis_cnt_q, mis_cnt_d;

    logic [IDX_W-1:0] lk_idx, upd_idx;
    logic [TAG_W-1:0] lk_tag, upd_tag;
    logic             lk_hit, upd_hit;
    logic             act;
    logic             mispredict;
    ctr_e             ctr_nxt;
    logic             unused_pc_bits;

    assign lk_idx  = bp.if_pc[IDX_W+1:2];
    assign lk_tag  = bp.if_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign upd_idx = bp.res_pc[IDX_W+1:2];
    assign upd_tag = bp.res_pc[IDX_W+TAG_W+1:IDX_W+2];

    // Only index/tag bits of the fetch PC participate in the lookup.
    assign unused_pc_bits = ^{bp.if_pc[31:IDX_W+TAG_W+2], bp.if_pc[1:0]};

    // Lookup reads the registered table only: an update to the same entry
    // in this cycle is not visible until the next cycle.
    assign lk_hit         = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign bp.pred_taken  = rst_n && lk_hit && ctr_q[lk_idx][1];
    assign bp.pred_target = target_q[lk_idx];

    assign act     = bp.res_valid && !bp.id_stall && !bp.id_flush;
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    // A taken/taken pair still mispredicts when the targets differ.
    assign mispredict = rst_n && act &&
                        ((bp.res_taken != pid_taken_q) ||
                         (bp.res_taken && (pid_target_q != bp.res_target)));

    assign bp.mispredict     = mispredict;
    assign bp.redirect_pc    = (mispredict && bp.res_taken) ? bp.res_target
                                                            : bp.res_pc + DELAY_SLOT_OFFSET;
    assign bp.mispredict_cnt = mis_cnt_q;

    sat_counter2 u_sat_counter2 (
        .cur   (ctr_q[upd_idx]),
        .taken (bp.res_taken),
        .nxt   (ctr_nxt)
    );

    always_comb begin
        for (int i = 0; i < N; i++) begin
            valid_d[i]  = valid_q[i];
            tag_d[i]    = tag_q[i];
            target_d[i] = target_q[i];
            ctr_d[i]    = ctr_q[i];
        end
        if (act) begin
            if (upd_hit) begin
                ctr_d[upd_idx] = ctr_nxt;
                if (bp.res_taken) target_d[upd_idx] = bp.res_target;
            end else if (bp.res_taken) begin
                // Taken miss evicts whatever aliases into this slot.
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = bp.res_target;
                ctr_d[upd_idx]    = CTR_WT;
            end
        end
    end

    always_comb begin
        pid_taken_d  = pid_taken_q;
        pid_target_d = pid_target_q;
        // A mispredict squashes the instruction currently in IF, so its
        // prediction must not reach ID.
        if (bp.id_flush || mispredict) begin
            pid_taken_d  = 1'b0;
            pid_target_d = 32'd0;
        end else if (!bp.id_stall) begin
            pid_taken_d  = bp.pred_taken;
            pid_target_d = bp.pred_target;
        end
    end

    assign mis_cnt_d = mispredict ? mis_cnt_q + 32'd1 : mis_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= 32'd0;
                ctr_q[i]    <= CTR_WNT;
            end
            pid_taken_q  <= 1'b0;
            pid_target_q <= 32'd0;
            mis_cnt_q    <= 32'd0;
        end else begin
            for (int i = 0; i < N; i++) begin
                valid_q[i]  <= valid_d[i];
                tag_q[i]    <= tag_d[i];
                target_q[i] <= target_d[i];
                ctr_q[i]    <= ctr_d[i];
            end
            pid_taken_q  <= pid_taken_d;
            pid_target_q <= pid_target_d;
            mis_cnt_q    <= mis_cnt_d;
        end
    end

endmodule
